// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and width helpers for the FIFO write-side arbiter
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero for single-entry vectors.
    function automatic int log2_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - producer/FIFO write-port bundle seen by the arbiter
interface fifo_wr_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SZIE = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_SZIE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         fifo_wr;
    logic [DATA_SZIE-1:0]         fifo_din;
    logic                         fifo_full;
    logic [NUM_REQ-1:0]           grant;
    logic                         busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_din, grant, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_din, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arb_core.sv
// rtl/fifo_wr_arb_core.sv - IDLE/XFER grant FSM with burst limit and write steering
module fifo_wr_arb_core
    import fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SZIE = 8,
    parameter int BURST_MAX = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    fifo_wr_arb_if.slave bus
);

    localparam int IDX_W = log2_width(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               wr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (IDX_W)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (last_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = IDX_W'(i);
            end
        end
    end

    // Reset gates the strobe combinationally so a burst dies in the reset cycle itself.
    assign wr            = (state_q == XFER) & bus.req_valid[gidx_q] & ~bus.fifo_full & rstn_i;
    assign bus.fifo_wr   = wr;
    assign bus.req_ready = wr ? grant_q : '0;
    assign bus.fifo_din  = wr ? bus.req_data[gidx_q*DATA_SZIE +: DATA_SZIE] : '0;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == XFER);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d = XFER;
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (wr) begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.req_last[gidx_q] || cnt_d == CNT_W'(BURST_MAX)) begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        last_d  = gidx_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the pointer
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = log2_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                gnt_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter sharing one sync_fifo write port
module fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SZIE = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_SZIE-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         fifo_wr_o,
    output logic [DATA_SZIE-1:0]         fifo_din_o,
    input  logic                         fifo_full_i,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o
);

    fifo_wr_arb_if #(
        .NUM_REQ   (NUM_REQ),
        .DATA_SZIE (DATA_SZIE)
    ) bus ();

    assign bus.req_valid = req_valid_i;
    assign bus.req_data  = req_data_i;
    assign bus.req_last  = req_last_i;
    assign bus.fifo_full = fifo_full_i;
    assign req_ready_o   = bus.req_ready;
    assign fifo_wr_o     = bus.fifo_wr;
    assign fifo_din_o    = bus.fifo_din;
    assign grant_o       = bus.grant;
    assign busy_o        = bus.busy;

    fifo_wr_arb_core #(
        .NUM_REQ   (NUM_REQ),
        .DATA_SZIE (DATA_SZIE),
        .BURST_MAX (BURST_MAX)
    ) u_core (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of producers sharing one sync_fifo write port.
REQ-002 SHALL have parameter DATA_SZIE, default 8: data width, equal to the FIFO's DATA_SZIE.
REQ-003 SHALL have parameter BURST_MAX, default 4: maximum beats per grant.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester data valid.
REQ-007 SHALL have port req_data_i  input  NUM_REQ*DATA_SZIE  packed data; requester k occupies bits [k*DATA_SZIE +: DATA_SZIE].
REQ-008 SHALL have port req_last_i  input  NUM_REQ  per-requester last beat of packet.
REQ-009 SHALL have port req_ready_o  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-010 SHALL have port fifo_wr_o  output  1  FIFO write strobe.
REQ-011 SHALL have port fifo_din_o  output  DATA_SZIE  FIFO write data.
REQ-012 SHALL have port fifo_full_i  input  1  FIFO full flag.
REQ-013 SHALL have port grant_o  output  NUM_REQ  one-hot current owner; all zero when idle.
REQ-014 SHALL have port busy_o  output  1  high while in state XFER.

Function
REQ-015 SHALL implement FSM with states IDLE and XFER.
REQ-016 IDLE: any req_valid_i bit high at a clock edge -> register winner into grant, go to XFER; otherwise stay IDLE.
REQ-017 Winner selection SHALL be round-robin: search starts at index (last winner + 1) mod NUM_REQ, first set valid bit wins.
REQ-018 Latency: valid raised in cycle N while IDLE -> grant_o one-hot in cycle N+1, first write possible in N+1.
REQ-019 In XFER, with g = granted index: fifo_wr_o = req_valid_i[g] & !fifo_full_i & rstn_i, combinational.
REQ-020 req_ready_o[g] SHALL equal fifo_wr_o; all other req_ready_o bits SHALL be 0.
REQ-021 fifo_din_o SHALL equal req_data_i slice g when fifo_wr_o=1, else all zeros.
REQ-022 A beat is accepted when fifo_wr_o=1; beat counter (width $clog2(BURST_MAX)+1) increments per accepted beat.
REQ-023 Grant release: an accepted beat with req_last_i[g]=1, or the accepted beat bringing the count to BURST_MAX -> return to IDLE next cycle, clear counter, record g as last winner.
REQ-024 fifo_full_i=1 in XFER: no write, no count, grant held indefinitely.
REQ-025 Granted requester drops valid without last: grant held; no timeout.
REQ-026 Release is followed by exactly one IDLE arbitration cycle (bubble); no back-to-back grant.
REQ-027 In IDLE: fifo_wr_o=0, req_ready_o=0, grant_o=0, busy_o=0.
REQ-028 A sole active requester SHALL be re-granted after its own release (pointer wrap).

Reset
REQ-029 rstn_i=0 at a rising edge SHALL force IDLE, beat counter 0, last-winner pointer NUM_REQ-1 (requester 0 highest priority).
REQ-030 While rstn_i=0: fifo_wr_o=0, req_ready_o=0, fifo_din_o=0; after the edge, grant_o=0 and busy_o=0.
REQ-031 Reset mid-XFER SHALL abandon the burst without further writes; no partial state survives.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the arb_state_e typedef (IDLE, XFER) and a log2 width helper used by the FIFO.
REQ-033 Round-robin pick SHALL be the combinational sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot winner).

Verification
REQ-034 Reset; req_valid_i=4'b1010, none full -> grant_o=4'b0010 in cycle N+1; BURST_MAX=4 beats written; IDLE bubble; then grant_o=4'b1000.
REQ-035 Requester 0 sends 2 beats with last on beat 2 -> exactly 2 fifo_wr_o pulses, grant_o=0 one cycle later.
REQ-036 Requester 2 granted, fifo_full_i=1 for 3 cycles mid-burst -> no writes, grant_o stays 4'b0100, counter resumes, 4 total beats.
REQ-037 All 4 valid continuously, last on every beat -> grant order 0,1,2,3,0, each with one-cycle bubble.
REQ-038 rstn_i=0 for one cycle after 2 beats of a burst -> fifo_wr_o=0 that cycle, IDLE next, next grant goes to lowest valid index.
